tdm_demux4: RTL

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Four-slot serial TDM demultiplexer: locks on frame_sync, assembles MSB-first
// slots and publishes all four words together once a full frame has arrived.
module tdm_demux4 #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked
);

    localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [1:0]      LAST_SLOT = 2'(NCH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bitCnt_q, bitCnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold0_q, hold0_d;
    logic [WIDTH-1:0] hold1_q, hold1_d;
    logic [WIDTH-1:0] hold2_q, hold2_d;
    logic [WIDTH-1:0] ch0_q, ch0_d;
    logic [WIDTH-1:0] ch1_q, ch1_d;
    logic [WIDTH-1:0] ch2_q, ch2_d;
    logic [WIDTH-1:0] ch3_q, ch3_d;
    logic             frameValid_q, frameValid_d;
    logic             syncErr_q, syncErr_d;

    logic [WIDTH-1:0] nextWord;
    logic [WIDTH-1:0] firstWord;
    logic             atFrameStart;

    // nextWord is the shift path; the slot-3 word goes straight to ch3 from it.
    assign nextWord     = {shift_q[WIDTH-2:0], din};
    assign firstWord    = {{(WIDTH-1){1'b0}}, din};
    assign atFrameStart = (slot_q == 2'd0) && (bitCnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            slot_q       <= '0;
            shift_q      <= '0;
            hold0_q      <= '0;
            hold1_q      <= '0;
            hold2_q      <= '0;
            ch0_q        <= '0;
            ch1_q        <= '0;
            ch2_q        <= '0;
            ch3_q        <= '0;
            frameValid_q <= 1'b0;
            syncErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            slot_q       <= slot_d;
            shift_q      <= shift_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
            hold2_q      <= hold2_d;
            ch0_q        <= ch0_d;
            ch1_q        <= ch1_d;
            ch2_q        <= ch2_d;
            ch3_q        <= ch3_d;
            frameValid_q <= frameValid_d;
            syncErr_q    <= syncErr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        slot_d       = slot_q;
        shift_d      = shift_q;
        hold0_d      = hold0_q;
        hold1_d      = hold1_q;
        hold2_d      = hold2_q;
        ch0_d        = ch0_q;
        ch1_d        = ch1_q;
        ch2_d        = ch2_q;
        ch3_d        = ch3_q;
        frameValid_d = 1'b0;
        syncErr_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_sync) begin
                        state_d  = RUN;
                        shift_d  = firstWord;
                        bitCnt_d = CW'(1);
                        slot_d   = 2'd0;
                    end
                end
                RUN: begin
                    // A misplaced sync drops the partial frame and restarts on this bit.
                    if (frame_sync && !atFrameStart) begin
                        syncErr_d = 1'b1;
                        shift_d   = firstWord;
                        bitCnt_d  = CW'(1);
                        slot_d    = 2'd0;
                    end else begin
                        shift_d = nextWord;
                        if (bitCnt_q == LAST_BIT) begin
                            bitCnt_d = '0;
                            if (slot_q == LAST_SLOT) begin
                                ch0_d        = hold0_q;
                                ch1_d        = hold1_q;
                                ch2_d        = hold2_q;
                                ch3_d        = nextWord;
                                frameValid_d = 1'b1;
                                slot_d       = 2'd0;
                            end else begin
                                case (slot_q)
                                    2'd0:    hold0_d = nextWord;
                                    2'd1:    hold1_d = nextWord;
                                    default: hold2_d = nextWord;
                                endcase
                                slot_d = slot_q + 2'd1;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign ch0         = ch0_q;
    assign ch1         = ch1_q;
    assign ch2         = ch2_q;
    assign ch3         = ch3_q;
    assign frame_valid = frameValid_q;
    assign sync_err    = syncErr_q;
    assign locked      = (state_q == RUN);

endmodule
